gf2_poly_div_17bit: RTL
=======================

Name: gf2_poly_div_17bit

Overview:
- Sequential GF(2) polynomial long divider: the inverse of the 17-bit overlap-free Karatsuba carry-less multiplier.
- Takes a dividend of up to 33 bits (degree ≤ 32, i.e. a full multiplier product) and a 17-bit divisor.
- Produces quotient and remainder such that dividend = quotient·divisor XOR remainder, with deg(remainder) < deg(divisor).
- Processes one dividend bit per clock, MSB first. Sits behind the multiplier for reduction, check and round-trip use, with valid/ready handshakes on both sides.

Parameters:
- N, 17, divisor width; remainder width is N-1.
- DW, 2*N-1 (33), dividend and quotient width. Derived; do not override independently.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  dividend/divisor presented.
- in_ready  output  1  block can accept an operand pair.
- dividend  input  DW  dividend polynomial, bit i = coefficient of x^i.
- divisor  input  N  divisor polynomial, bit i = coefficient of x^i.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer accepts the result.
- quotient  output  DW  quotient polynomial.
- remainder  output  N-1  remainder polynomial.
- div_zero  output  1  divisor was all-zero; result is invalid, other outputs are 0.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, and all internal registers (operand, partial remainder r, degree, counter) = 0. Applies immediately, including mid-RUN; any operation in flight is discarded with no output.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: on the edge with in_valid=1:
  - Capture dividend and divisor.
  - Register deg = index of the highest set divisor bit (priority encode, 0..16).
  - Clear r (N bits) and the quotient shift register; set bit counter = DW-1.
  - Next state: RUN. If divisor==0, instead go to DONE with div_zero=1 and quotient=remainder=0.
- RUN: one step per edge, for bit index i = counter, counting down from DW-1 to 0:
  - t = {r[N-2:0], dividend[i]}.
  - qbit = t[deg].
  - r <= qbit ? t XOR divisor : t.
  - q <= {q[DW-2:0], qbit}.
  - After the step with i=0, go to DONE.
- Invariant: after each step, r bits at index ≥ deg are 0, so t never overflows N bits.
- RUN lasts exactly DW=33 edges. out_valid rises after the 34th rising edge counted from the accepting edge (accept edge + 33 steps).
- Outputs register at the transition into DONE:
  - quotient = q.
  - remainder = r[N-2:0]. Bits at index ≥ deg are guaranteed 0.
- DONE: outputs held stable while out_ready=0, for an unbounded stall.
  - On the edge with out_ready=1: go to IDLE, out_valid=0.
  - Output values are retained until overwritten by the next result.
- No input is accepted in RUN or DONE, since in_ready=0. An in_valid that is held is taken on the first IDLE edge. One pair is in flight at a time; throughput is 1 op per 35 cycles at best.
- deg=0 (divisor=1): quotient=dividend, remainder=0.
- deg=16: quotient degree ≤ 16, so bits DW-1..17 of the quotient are 0.
- Coefficient arithmetic is XOR only; no carries anywhere.

Test Plan:
- Reset with no traffic: in_ready=1, out_valid=0, all outputs 0. Then dividend=0xF, divisor=0x3 → quotient=0x5, remainder=0x0, div_zero=0, out_valid exactly 34 edges after acceptance.
- dividend=0xB, divisor=0x7 → quotient=0x3, remainder=0x2. dividend=0x1_2345_6789, divisor=0x1_0000 → quotient=0x1_2345, remainder=0x6789.
- divisor=0x00001 with dividend=0x1_FFFF_FFFF → quotient=0x1_FFFF_FFFF, remainder=0. divisor=0 → DONE on the next edge, div_zero=1, quotient=0, remainder=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → outputs stable, in_ready=0. Keep in_valid high with a second pair → it is accepted only on the edge after the out_ready handshake.
- Assert rst for 1 cycle at step 10 of RUN → immediate IDLE, out_valid never asserts for that op. The next op (0xB / 0x7) gives the correct result 0x3 / 0x2.
- Round-trip: 1000 random 17-bit a, b, feed dividend = clmul(a, b) with divisor = b (b≠0) → quotient=a, remainder=0. Feed dividend XOR random r with deg(r) < deg(b) → remainder=r.

Source files
------------

// File: rtl/gf2_poly_div_17bit.sv
// GF(2) polynomial long divider, one dividend bit per clock, MSB first.
// dividend = quotient * divisor XOR remainder, with deg(remainder) < deg(divisor).
module gf2_poly_div_17bit #(
  parameter  int unsigned N  = 17,
  localparam int unsigned DW = 2 * N - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [N-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [N-2:0]  remainder,
  output logic          div_zero
);

  localparam int unsigned RW    = N - 1;
  localparam int unsigned DEG_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [DW-1:0]    dvd;
  // Divisor top bit is never needed: when deg is 16 the XOR at bit 16 always cancels.
  logic [RW-1:0]    dvs;
  // Partial remainder; its bit N-1 is always zero by construction, so it is not stored.
  logic [RW-1:0]    r;
  // Quotient bits gathered so far; the last bit joins at the DONE transition.
  logic [DW-2:0]    q;
  logic [DEG_W-1:0] deg;
  logic [CNT_W-1:0] cnt;

  logic [DEG_W-1:0] deg_c;
  logic [N-1:0]     t_c;
  logic             qbit_c;
  logic [RW-1:0]    r_step_c;

  // Priority encoder: index of the highest set divisor bit.
  always_comb begin
    deg_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (divisor[i]) deg_c = DEG_W'(i);
    end
  end

  // One long-division step: shift in the next dividend bit, subtract divisor if it reaches deg.
  always_comb begin
    t_c      = {r, dvd[cnt]};
    qbit_c   = t_c[deg];
    r_step_c = qbit_c ? (t_c[RW-1:0] ^ dvs) : t_c[RW-1:0];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      r         <= '0;
      q         <= '0;
      deg       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd      <= dividend;
            dvs      <= divisor[RW-1:0];
            deg      <= deg_c;
            r        <= '0;
            q        <= '0;
            cnt      <= CNT_W'(DW - 1);
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quotient  <= '0;
              remainder <= '0;
              div_zero  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          r   <= r_step_c;
          q   <= {q[DW-3:0], qbit_c};
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= {q, qbit_c};
            remainder <= r_step_c;
            div_zero  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
